ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute-to-memory pipeline stage placed directly downstream of the ALU.
//  Captures the ALU result, flags and EX-stage control into a 2-entry skid buffer.
//  Exposes a valid/ready handshake on both sides, so memory-side stalls never drop an in-flight instruction.
//  Resolves the branch (PCSrc) from the ALU Zero flag for the instruction being accepted.
// PARAMETERS
//  DATA_W    32  width of ALU result, store data and PC
//  RADDR_W    5  destination register index width
// PORTS
//  clk            in   1        clock, all state updates on rising edge
//  rst            in   1        asynchronous, active-high reset
//  flush          in   1        synchronous kill of all buffered entries
//  ex_valid       in   1        EX presents a valid instruction
//  ex_ready       out  1        stage can accept this cycle
//  ex_result      in   DATA_W   ALU Result
//  ex_flags       in   4        {Negative,Zero,Carry,OverFlow} from the ALU
//  ex_wdata       in   DATA_W   forwarded rs2 value (store data)
//  ex_pc4         in   DATA_W   PC+4 of the instruction
//  ex_rd          in   RADDR_W  destination register
//  ex_ctrl        in   4        {RegWrite,MemWrite,ResultSrc[1:0]}
//  ex_branch      in   1        instruction is a conditional branch
//  pc_src         out  1        branch taken: ex_valid&ex_ready&~flush&ex_branch&ex_flags[2]
//  mem_valid      out  1        output entry valid
//  mem_ready      in   1        MEM stage consumes output entry
//  mem_result/mem_flags/mem_wdata/mem_pc4/mem_rd/mem_ctrl  out  same widths  registered copies
// BEHAVIOUR
//  - acc = ex_valid & ex_ready; drn = mem_valid & mem_ready.
//  - Storage: main register (drives mem_* outputs) and skid register; each has a valid bit.
//  - ex_ready = ~skid_valid. It is registered-derived with no combinational path from mem_ready.
//  - States: EMPTY (neither valid), ONE (main only), TWO (main+skid).
//    - EMPTY: acc -> ONE, main<=in.
//    - ONE: acc&drn -> ONE, main<=in. acc&~drn -> TWO, skid<=in. ~acc&drn -> EMPTY. Else hold.
//    - TWO: ex_ready=0. drn -> ONE, main<=skid. Else hold all.
//  - Order is strict FIFO: skid contents always leave before any newer input.
//  - Latency: 1 cycle from acc to mem_valid when EMPTY. Throughput is 1/cycle with mem_ready=1.
//  - flush (priority over everything): next state EMPTY.
//    - Both valid bits cleared; input in the flush cycle is not captured; pc_src forced 0.
//    - Data registers may hold stale values; only valid bits are defined after flush.
//  - mem_* fields must not change while mem_valid=1 and mem_ready=0, except by flush or reset.
//  - ctrl bits of an invalid entry are don't-care. Downstream qualifies RegWrite/MemWrite with mem_valid.
//  - All fields pass through unmodified with no width change. Flags are stored as given, not recomputed.
//  - rst asserted at any time, including mid-transfer: state EMPTY immediately.
//    - mem_valid=0, all mem_* data/ctrl = 0, ex_ready=1 during and after reset.
//  - pc_src is purely combinational from current inputs and state; it has no registered copy.
// TESTING
//  1. Reset mid-stream: TWO state with rst pulse -> mem_valid=0, mem_result=0, ex_ready=1 same cycle.
//  2. Streaming: mem_ready=1, results 1..8 back-to-back -> mem_result 1..8 one cycle later, no bubbles.
//  3. Backpressure: hold mem_ready=0, send 0xA,0xB,0xC -> state TWO, ex_ready=0, 0xC held by EX.
//     Release -> outputs 0xA,0xB,0xC in order.
//  4. Branch: ex_branch=1, ex_flags=4'b0100, acc -> pc_src=1. Repeat with ex_flags=0 -> pc_src=0.
//     Repeat while ex_ready=0 -> pc_src=0.
//  5. Flush in TWO with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, new input not captured.
//  6. Simultaneous acc&drn in ONE: 0x10 in main, send 0x20 -> main=0x20, skid_valid stays 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Brief    : EX->MEM pipeline stage. A 2-entry skid buffer (main + skid)
//             with valid/ready on both sides; resolves the branch decision
//             (pc_src) for the instruction accepted this cycle.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  // EX side
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [3:0]         ex_flags,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [DATA_W-1:0]  ex_pc4,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [3:0]         ex_ctrl,
  input  logic               ex_branch,
  output logic               pc_src,
  // MEM side
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [DATA_W-1:0]  mem_result,
  output logic [3:0]         mem_flags,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  mem_pc4,
  output logic [RADDR_W-1:0] mem_rd,
  output logic [3:0]         mem_ctrl
);

  // One buffered instruction: {result, flags, wdata, pc4, rd, ctrl}
  localparam int BW = 3 * DATA_W + RADDR_W + 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   main_q;
  logic [BW-1:0]   skid_q;
  logic            main_valid_q;
  logic            skid_valid_q;

  logic [BW-1:0]   ex_bundle;
  logic            acc;
  logic            drn;

  assign ex_bundle = {ex_result, ex_flags, ex_wdata, ex_pc4, ex_rd, ex_ctrl};

  // Ready depends only on state, so mem_ready never reaches ex_ready.
  assign ex_ready  = ~skid_valid_q;
  assign mem_valid = main_valid_q;
  assign acc       = ex_valid & ex_ready;
  assign drn       = main_valid_q & mem_ready;

  // Branch taken only for an instruction actually accepted this cycle.
  assign pc_src = acc & ~flush & ex_branch & ex_flags[2];

  assign {mem_result, mem_flags, mem_wdata, mem_pc4, mem_rd, mem_ctrl} = main_q;

  // Skid-buffer FSM; valid bits are registered alongside the state so the
  // handshake outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_q       <= ex_bundle;
            main_valid_q <= 1'b1;
            state_q      <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_q <= ex_bundle;
          end else if (acc) begin
            skid_q       <= ex_bundle;
            skid_valid_q <= 1'b1;
            state_q      <= TWO;
          end else if (drn) begin
            main_valid_q <= 1'b0;
            state_q      <= EMPTY;
          end
        end
        TWO: begin
          // Input is blocked here, so the skid entry always leaves next.
          if (drn) begin
            main_q       <= skid_q;
            skid_valid_q <= 1'b0;
            state_q      <= ONE;
          end
        end
        default: begin
          state_q      <= EMPTY;
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Brief    : Directed, table-driven self-checking bench for ex_mem_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               ex_valid;
  logic               ex_ready;
  logic [DATA_W-1:0]  ex_result;
  logic [3:0]         ex_flags;
  logic [DATA_W-1:0]  ex_wdata;
  logic [DATA_W-1:0]  ex_pc4;
  logic [RADDR_W-1:0] ex_rd;
  logic [3:0]         ex_ctrl;
  logic               ex_branch;
  logic               pc_src;
  logic               mem_valid;
  logic               mem_ready;
  logic [DATA_W-1:0]  mem_result;
  logic [3:0]         mem_flags;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_pc4;
  logic [RADDR_W-1:0] mem_rd;
  logic [3:0]         mem_ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_flags(ex_flags), .ex_wdata(ex_wdata),
    .ex_pc4(ex_pc4), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_branch(ex_branch), .pc_src(pc_src),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_result(mem_result), .mem_flags(mem_flags), .mem_wdata(mem_wdata),
    .mem_pc4(mem_pc4), .mem_rd(mem_rd), .mem_ctrl(mem_ctrl)
  );

  always #5 clk = ~clk;

  // Side fields are derived from the result so every field is distinct.
  function automatic logic [DATA_W-1:0] f_wdata(input logic [DATA_W-1:0] r);
    return ~r;
  endfunction
  function automatic logic [DATA_W-1:0] f_pc4(input logic [DATA_W-1:0] r);
    return r + 32'd4;
  endfunction
  function automatic logic [RADDR_W-1:0] f_rd(input logic [DATA_W-1:0] r);
    return r[RADDR_W-1:0] ^ 5'h15;
  endfunction
  function automatic logic [3:0] f_ctrl(input logic [DATA_W-1:0] r);
    return r[3:0] ^ 4'hA;
  endfunction

  typedef struct {
    logic              rst, fl, v;
    logic [DATA_W-1:0] res;
    logic [3:0]        flg;
    logic              br, mr;
    logic              e_rdy, e_pc;   // checked before the clock edge
    logic              e_mv;          // checked after the clock edge
    logic [DATA_W-1:0] e_res;
    logic [3:0]        e_flg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic fl, input logic v,
                     input logic [DATA_W-1:0] res, input logic [3:0] flg,
                     input logic br, input logic mr,
                     input logic e_rdy, input logic e_pc, input logic e_mv,
                     input logic [DATA_W-1:0] e_res, input logic [3:0] e_flg);
    vec_t t;
    t.rst = r; t.fl = fl; t.v = v; t.res = res; t.flg = flg; t.br = br;
    t.mr = mr; t.e_rdy = e_rdy; t.e_pc = e_pc; t.e_mv = e_mv;
    t.e_res = e_res; t.e_flg = e_flg;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst       = t.rst;
    flush     = t.fl;
    ex_valid  = t.v;
    ex_result = t.res;
    ex_flags  = t.flg;
    ex_wdata  = f_wdata(t.res);
    ex_pc4    = f_pc4(t.res);
    ex_rd     = f_rd(t.res);
    ex_ctrl   = f_ctrl(t.res);
    ex_branch = t.br;
    mem_ready = t.mr;
  endtask

  initial begin
    // Streaming: results 1..8 back-to-back with mem_ready=1, no bubbles
    for (int k = 1; k <= 8; k++)
      add(0,0,1, k, k[3:0], 0,1,  1,0, 1, k, k[3:0]);
    add(0,0,0, 0, 0, 0,1,  1,0, 0, 0, 0);
    // Backpressure: A,B fill the buffer, C is held off by EX
    add(0,0,1, 32'hA, 4'h1, 0,0,  1,0, 1, 32'hA, 4'h1);
    add(0,0,1, 32'hB, 4'h2, 0,0,  1,0, 1, 32'hA, 4'h1);
    add(0,0,1, 32'hC, 4'h3, 0,0,  0,0, 1, 32'hA, 4'h1);
    add(0,0,1, 32'hC, 4'h3, 0,0,  0,0, 1, 32'hA, 4'h1);
    add(0,0,1, 32'hC, 4'h3, 0,1,  0,0, 1, 32'hB, 4'h2);
    add(0,0,1, 32'hC, 4'h3, 0,1,  1,0, 1, 32'hC, 4'h3);
    add(0,0,0, 0, 0, 0,1,  1,0, 0, 0, 0);
    // Branch: taken, not taken (Z=0), blocked while ex_ready=0
    add(0,0,1, 32'h30, 4'b0100, 1,0,  1,1, 1, 32'h30, 4'b0100);
    add(0,0,1, 32'h31, 4'b0000, 1,0,  1,0, 1, 32'h30, 4'b0100);
    add(0,0,1, 32'h32, 4'b0100, 1,0,  0,0, 1, 32'h30, 4'b0100);
    // Flush in TWO with ex_valid=1: everything invalid, input dropped
    add(0,1,1, 32'h33, 4'b0100, 1,0,  0,0, 0, 0, 0);
    add(0,0,0, 0, 0, 0,0,  1,0, 0, 0, 0);
    // Flush suppresses pc_src even when the stage is ready
    add(0,1,1, 32'h34, 4'b0100, 1,0,  1,0, 0, 0, 0);
    // Simultaneous acc&drn in ONE: main replaced, skid stays empty
    add(0,0,1, 32'h10, 4'h5, 0,0,  1,0, 1, 32'h10, 4'h5);
    add(0,0,1, 32'h20, 4'h6, 0,1,  1,0, 1, 32'h20, 4'h6);
    add(0,0,1, 32'h21, 4'h7, 0,0,  1,0, 1, 32'h20, 4'h6);
    add(0,0,0, 0, 0, 0,1,  0,0, 1, 32'h21, 4'h7);
    add(0,0,0, 0, 0, 0,1,  1,0, 0, 0, 0);
    // Reset mid-stream from TWO
    add(0,0,1, 32'h40, 4'h8, 0,0,  1,0, 1, 32'h40, 4'h8);
    add(0,0,1, 32'h41, 4'h9, 0,0,  1,0, 1, 32'h40, 4'h8);
    add(1,0,1, 32'h42, 4'hA, 0,0,  1,0, 0, 0, 0);
    add(0,0,0, 0, 0, 0,1,  1,0, 0, 0, 0);

    // Power-on reset
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_flags = '0;
    ex_wdata = '0; ex_pc4 = '0; ex_rd = '0; ex_ctrl = '0; ex_branch = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_ex_ready",  64'(ex_ready),  64'd1);
    chk("rst_mem_result", 64'(mem_result), 64'd0);
    chk("rst_mem_ctrl",  64'(mem_ctrl),  64'd0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_ex_ready", i), 64'(ex_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_pc_src", i),   64'(pc_src),   64'(tbl[i].e_pc));
      if (tbl[i].rst) begin
        // Asynchronous reset takes effect without waiting for a clock
        chk($sformatf("v%0d_rst_mv_now", i),  64'(mem_valid),  64'd0);
        chk($sformatf("v%0d_rst_res_now", i), 64'(mem_result), 64'd0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mem_valid", i), 64'(mem_valid), 64'(tbl[i].e_mv));
      if (tbl[i].rst) begin
        chk($sformatf("v%0d_rst_result", i), 64'(mem_result), 64'd0);
        chk($sformatf("v%0d_rst_flags", i),  64'(mem_flags),  64'd0);
        chk($sformatf("v%0d_rst_wdata", i),  64'(mem_wdata),  64'd0);
        chk($sformatf("v%0d_rst_pc4", i),    64'(mem_pc4),    64'd0);
        chk($sformatf("v%0d_rst_rd", i),     64'(mem_rd),     64'd0);
        chk($sformatf("v%0d_rst_ctrl", i),   64'(mem_ctrl),   64'd0);
      end else if (tbl[i].e_mv) begin
        chk($sformatf("v%0d_result", i), 64'(mem_result), 64'(tbl[i].e_res));
        chk($sformatf("v%0d_flags", i),  64'(mem_flags),  64'(tbl[i].e_flg));
        chk($sformatf("v%0d_wdata", i),  64'(mem_wdata),  64'(f_wdata(tbl[i].e_res)));
        chk($sformatf("v%0d_pc4", i),    64'(mem_pc4),    64'(f_pc4(tbl[i].e_res)));
        chk($sformatf("v%0d_rd", i),     64'(mem_rd),     64'(f_rd(tbl[i].e_res)));
        chk($sformatf("v%0d_ctrl", i),   64'(mem_ctrl),   64'(f_ctrl(tbl[i].e_res)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
